// File: rtl/puf_eval_sched.sv
// puf_eval_sched -- evaluation scheduler for the arbiter-PUF array.
//
// Accepts one challenge at a time over a valid/ready handshake and drives the
// array through clear, launch (arm), settle and capture phases. It then returns
// the captured response word, tagged with a wrapping sequence number.
//
// Optional build macro: PUF_MAJ_VOTE_EN
//   When defined, each challenge is evaluated three times. The response is the
//   bitwise majority of the three captures.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_en                  scheduler enable (gates new acceptance only)
//   cfg_settle[CNT_W]       settle cycles after launch (0 behaves as 1)
//   chal_valid/ready/data   challenge input handshake
//   puf_chal, puf_clr,
//   puf_arm                 array control: applied challenge, clear, launch
//   puf_rsp[PUF_N]          synchronised arbiter outputs
//   rsp_valid/ready/data,
//   rsp_tag                 response output handshake with sequence tag
//   busy                    high whenever the scheduler is not idle
module puf_eval_sched #(
  parameter int CHAL_W = 24,
  parameter int PUF_N  = 16,
  parameter int CNT_W  = 5,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [CNT_W-1:0]  cfg_settle,
  input  logic              chal_valid,
  input  logic [CHAL_W-1:0] chal_data,
  output logic              chal_ready,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_clr,
  output logic              puf_arm,
  input  logic [PUF_N-1:0]  puf_rsp,
  output logic              rsp_valid,
  output logic [PUF_N-1:0]  rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] ARM     = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

`ifdef PUF_MAJ_VOTE_EN
  logic [1:0]       eval_cnt;
  logic [PUF_N-1:0] samp0;
  logic [PUF_N-1:0] samp1;
`endif

  // Control outputs decode directly from state, so an asynchronous reset
  // clears them in the same cycle. chal_ready is also gated by rst_n.
  // Without that gate it would follow cfg_en while reset is held.
  assign chal_ready = rst_n & cfg_en & (state == IDLE);
  assign puf_clr    = (state == CLEAR);
  assign puf_arm    = (state == ARM);
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      puf_chal <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
`ifdef PUF_MAJ_VOTE_EN
      eval_cnt <= '0;
      samp0    <= '0;
      samp1    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (chal_valid && chal_ready) begin
            puf_chal <= chal_data;
`ifdef PUF_MAJ_VOTE_EN
            eval_cnt <= '0;
`endif
            state    <= CLEAR;
          end
        end
        CLEAR: state <= ARM;
        ARM: begin
          cnt   <= (cfg_settle == '0) ? CNT_ONE : cfg_settle;
          state <= SETTLE;
        end
        SETTLE: begin
          // Counter starts at S and leaves at 1, giving exactly S cycles here.
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= CAPTURE;
        end
        CAPTURE: begin
`ifdef PUF_MAJ_VOTE_EN
          case (eval_cnt)
            2'd0:    samp0 <= puf_rsp;
            2'd1:    samp1 <= puf_rsp;
            default: rsp_data <= (samp0 & samp1) | (samp0 & puf_rsp) |
                                 (samp1 & puf_rsp);
          endcase
          eval_cnt <= eval_cnt + 2'd1;
          state    <= (eval_cnt == 2'd2) ? RESP : CLEAR;
`else
          rsp_data <= puf_rsp;
          state    <= RESP;
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_tag <= rsp_tag + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/puf_eval_sched.md
# puf_eval_sched

Evaluation scheduler for the arbiter-PUF array in the PUF SoC. It accepts challenges from the host-side frame receiver over a valid/ready handshake and applies each one to all PUF instances. It sequences clear, launch, settle and capture phases, then returns the tagged response word to the host transmit path. It is the only block that drives the PUF array's control pins.

## Interface
- CHAL_W, 24 — challenge width; one bit per PUF stage (NO_PUF_STAGE).
- PUF_N, 16 — number of PUF instances; also the response width (PUF_LENGTH).
- CNT_W, 5 — settle-counter width (CNT_BIT_SIZE).
- TAG_W, 8 — response sequence-tag width (REG_BIT_SIZE).

Ports:
- clk  in  1  — single clock; all logic on its rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- cfg_en  in  1  — scheduler enable.
- cfg_settle  in  CNT_W  — settle cycles S after launch; a value of 0 is treated as 1.
- chal_valid  in  1  — challenge available.
- chal_data  in  CHAL_W  — challenge bits.
- chal_ready  out  1  — scheduler accepts a challenge.
- puf_chal  out  CHAL_W  — challenge applied to the array.
- puf_clr  out  1  — one-cycle clear of the arbiter latches.
- puf_arm  out  1  — one-cycle launch pulse.
- puf_rsp  in  PUF_N  — arbiter outputs, already synchronised upstream.
- rsp_valid  out  1  — response available.
- rsp_data  out  PUF_N  — response word.
- rsp_tag  out  TAG_W  — sequence number of this response.
- rsp_ready  in  1  — downstream accepts the response.
- busy  out  1  — high whenever the state is not IDLE.

## Operation
- States: IDLE, CLEAR, ARM, SETTLE, CAPTURE, RESP.
- IDLE:
  - chal_ready = cfg_en.
  - On chal_valid & chal_ready: latch chal_data into puf_chal, clear the eval counter, go to CLEAR.
- CLEAR: puf_clr = 1 for one cycle; go to ARM.
- ARM: puf_arm = 1 for one cycle; load the settle counter with max(cfg_settle, 1); go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to CAPTURE. SETTLE therefore lasts exactly S cycles.
- CAPTURE: sample puf_rsp into the capture register, then:
  - with voting compiled out, go to RESP;
  - with voting compiled in, see Configuration.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_tag are held stable.
  - On rsp_ready: increment the tag (modulo 2^TAG_W, so 255 wraps to 0) and go to IDLE.
- puf_chal holds the last accepted challenge until the next acceptance.
- cfg_settle is sampled only in ARM. Later changes do not affect the evaluation in progress.
- cfg_en deasserted mid-evaluation: the current evaluation completes normally. Only new acceptance is blocked.
- puf_rsp is ignored in every state except CAPTURE.

## Timing
- Reset values:
  - state IDLE;
  - puf_chal = 0;
  - puf_clr, puf_arm, rsp_valid, busy = 0;
  - rsp_data = 0, rsp_tag = 0;
  - chal_ready = 0 (it follows cfg_en once reset is released).
- Challenge accepted at edge T (no voting):
  - puf_clr high in cycle T+1;
  - puf_arm high in cycle T+2;
  - SETTLE occupies cycles T+3 to T+2+S;
  - CAPTURE in cycle T+3+S;
  - rsp_valid rises at T+4+S.
- With voting: rsp_valid rises at T+3(S+3)+1.
- A response handshake at edge R returns the state to IDLE at R+1. Minimum challenge-to-challenge spacing is therefore S+5 cycles.
- Reset asserted mid-operation: all state is discarded immediately and outputs return to reset values. No response is emitted.
- Only one challenge is ever outstanding; there is no buffering.

## Configuration
- PUF_MAJ_VOTE_EN defined:
  - Each challenge is evaluated 3 times; every evaluation repeats CLEAR through CAPTURE.
  - After the 3rd CAPTURE, each rsp_data bit is the bitwise majority of the three samples.
  - A 2-bit eval counter and two extra PUF_N-bit sample registers are added.
- PUF_MAJ_VOTE_EN undefined: a single evaluation, and rsp_data is the single sample. The extra registers and counter are absent.

## Test plan
- Reset, then cfg_en=1, cfg_settle=4, challenge 0xA5A5A5, puf_rsp=0x3C3C, rsp_ready held high:
  - expect puf_clr at T+1 and puf_arm at T+2;
  - expect rsp_valid at T+8 with rsp_data=0x3C3C and rsp_tag=0;
  - expect chal_ready back high at T+9.
- cfg_settle=0: expect identical timing to cfg_settle=1, with rsp_valid at T+5.
- Hold rsp_ready low for 10 cycles:
  - expect rsp_valid, rsp_data and rsp_tag stable and chal_ready=0;
  - a chal_valid pulse during this time must not be accepted.
- Run 257 back-to-back challenges: expect rsp_tag to go 0…255, then 0 for the 257th.
- Drop cfg_en during SETTLE:
  - expect the response to still be delivered;
  - expect chal_ready to stay 0 afterwards;
  - then pull rst_n low in SETTLE of a new run and expect all outputs to be 0 in the same cycle.
- PUF_MAJ_VOTE_EN, S=2, puf_rsp sequence 0x00FF / 0x0F0F / 0x0FF0 across the three captures:
  - expect rsp_data=0x0FFF at T+16.
